vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch, pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width, pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch, pixels.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch, lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width, lines.
REQ-008 Parameter V_BP, default 33, vertical back porch, lines.
REQ-009 Parameter SYNC_POL, default 0, asserted level of hs/vs (0 = active-low).
REQ-010 vga_clk  input  1  single clock; all state changes on its rising edge.
REQ-011 Reset  input  1  synchronous, active-high reset.
REQ-012 pix_ce  input  1  pixel clock enable; counters and outputs advance only on cycles where it is 1.
REQ-013 DrawX  output  10  current pixel column (horizontal counter hc).
REQ-014 DrawY  output  10  current line (vertical counter vc).
REQ-015 hs  output  1  horizontal sync, level per SYNC_POL.
REQ-016 vs  output  1  vertical sync, level per SYNC_POL.
REQ-017 blank  output  1  display enable: 1 inside the visible area, 0 otherwise (downstream sprite/palette stages gate RGB on blank=1).
REQ-018 frame_start  output  1  one-pixel pulse, 1 exactly when (DrawX,DrawY)=(0,0).

Function
REQ-019 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800), V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525); both SHALL be <= 1024.
REQ-020 hc counts 0..H_TOTAL-1 and increments by 1 on each cycle with pix_ce=1; at H_TOTAL-1 it wraps to 0.
REQ-021 vc increments by 1 only on the pix_ce cycle where hc wraps; at V_TOTAL-1 it wraps to 0 on that same cycle (hc and vc wrap together at the frame end).
REQ-022 All outputs are registers; each is the decode of the (hc,vc) pair presented on DrawX/DrawY in the same cycle (zero skew between position and control outputs).
REQ-023 blank = 1 iff hc < H_ACTIVE and vc < V_ACTIVE.
REQ-024 hs asserted iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (default 656..751).
REQ-025 vs asserted iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC (default 490..491), for the entire line including hc=0..H_TOTAL-1.
REQ-026 frame_start = 1 iff hc=0 and vc=0; it lasts one pix_ce period (holds while pix_ce=0).
REQ-027 pix_ce=0: every register holds its value; no output changes.
REQ-028 Counter arithmetic is 10-bit unsigned; no other wrap than REQ-020/021 occurs.

Reset
REQ-029 Reset=1 on a rising edge (regardless of pix_ce) loads hc=H_TOTAL-1, vc=V_TOTAL-1 (DrawX=799, DrawY=524), blank=0, hs=vs=deasserted, frame_start=0.
REQ-030 First pix_ce=1 cycle after Reset deasserts moves to (0,0) with blank=1, frame_start=1.
REQ-031 Reset asserted mid-frame overrides counting in that same cycle; no partial-line state survives.

Verification
REQ-032 Reset, then pix_ce=1 constantly -> cycle 1: DrawX=0, DrawY=0, blank=1, frame_start=1; cycle 2: DrawX=1, frame_start=0.
REQ-033 Free-run one line -> blank falls at DrawX=640; hs=0 for exactly DrawX 656..751 (96 cycles); DrawX wraps 799->0 while DrawY 0->1.
REQ-034 Free-run one frame -> vs=0 for exactly lines 490..491 (1600 cycles); frame_start pulses every 420000 cycles; (799,524)->(0,0).
REQ-035 pix_ce toggled 1,0,1,0 -> DrawX advances only on pix_ce=1 cycles; frame_start held 2 cycles when pix_ce=0 follows (0,0).
REQ-036 Reset asserted at (300,200) with pix_ce=0 -> next edge DrawX=799, DrawY=524, blank=0, hs=vs=1.
REQ-037 SYNC_POL=1 build -> hs=1 only for DrawX 656..751, vs=1 only for lines 490..491, reset values hs=vs=0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters with registered, zero-skew sync, blank and
// frame-start decodes. All state advances only on pixel-clock-enable cycles.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       vga_clk,
    input  logic       Reset,
    input  logic       pix_ce,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_start
);

    localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] HLast = 10'(HTotal - 1);
    localparam logic [9:0] VLast = 10'(VTotal - 1);

    // Decode bounds carry an extra bit so an edge landing exactly on 1024 still compares.
    localparam logic [10:0] HActiveE = 11'(H_ACTIVE);
    localparam logic [10:0] HsStart  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HsEnd    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VActiveE = 11'(V_ACTIVE);
    localparam logic [10:0] VsStart  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VsEnd    = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       blank_q, blank_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       fs_q, fs_d;

    logic [9:0] hc_nx;
    logic [9:0] vc_nx;
    logic       hs_act_nx;
    logic       vs_act_nx;
    logic       blank_nx;

    // Position after one pixel step; hc and vc wrap together at the frame end.
    always_comb begin
        hc_nx = hc_q + 10'd1;
        vc_nx = vc_q;
        if (hc_q == HLast) begin
            hc_nx = '0;
            vc_nx = (vc_q == VLast) ? '0 : vc_q + 10'd1;
        end
    end

    // Outputs are decoded from the next position so they land in the same cycle as DrawX/Y.
    always_comb begin
        hs_act_nx = ({1'b0, hc_nx} >= HsStart) && ({1'b0, hc_nx} < HsEnd);
        vs_act_nx = ({1'b0, vc_nx} >= VsStart) && ({1'b0, vc_nx} < VsEnd);
        blank_nx  = ({1'b0, hc_nx} < HActiveE) && ({1'b0, vc_nx} < VActiveE);
    end

    always_comb begin
        hc_d    = hc_q;
        vc_d    = vc_q;
        blank_d = blank_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        fs_d    = fs_q;
        if (Reset) begin
            hc_d    = HLast;
            vc_d    = VLast;
            blank_d = 1'b0;
            hs_d    = ~SYNC_POL;
            vs_d    = ~SYNC_POL;
            fs_d    = 1'b0;
        end else if (pix_ce) begin
            hc_d    = hc_nx;
            vc_d    = vc_nx;
            blank_d = blank_nx;
            hs_d    = hs_act_nx ? SYNC_POL : ~SYNC_POL;
            vs_d    = vs_act_nx ? SYNC_POL : ~SYNC_POL;
            fs_d    = (hc_nx == 10'd0) && (vc_nx == 10'd0);
        end
    end

    always_ff @(posedge vga_clk) begin
        hc_q    <= hc_d;
        vc_q    <= vc_d;
        blank_q <= blank_d;
        hs_q    <= hs_d;
        vs_q    <= vs_d;
        fs_q    <= fs_d;
    end

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign blank       = blank_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign frame_start = fs_q;

endmodule
